// File: rtl/pitch_sdram_bridge.sv
// Bridges a level-held single-word client request onto an Avalon-MM pipelined master.
// Only one transaction is outstanding at a time. A per-transaction timeout aborts with pitch_err.
module pitch_sdram_bridge #(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              pitch_read,
  input  logic              pitch_write,
  input  logic [ADDR_W-1:0] pitch_addr,
  input  logic [DATA_W-1:0] pitch_writedata,
  output logic [DATA_W-1:0] pitch_readdata,
  output logic              pitch_sdram_finished,
  output logic              pitch_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic              timeout;
  logic              rd_nxt, wr_nxt, fin_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt, rdata_nxt;

  assign avm_byteenable = 4'hF;
  assign cnt_inc        = cnt + CNT_W'(1);
  assign timeout        = (cnt_inc == CNT_LIMIT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_nxt    = avm_read;
    wr_nxt    = avm_write;
    addr_nxt  = avm_address;
    wdata_nxt = avm_writedata;
    rdata_nxt = pitch_readdata;
    fin_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        // read has priority; a simultaneous write is picked up on a later IDLE cycle
        if (pitch_read) begin
          state_nxt = RD_REQ;
          rd_nxt    = 1'b1;
          addr_nxt  = pitch_addr;
          cnt_nxt   = '0;
        end else if (pitch_write) begin
          state_nxt = WR_REQ;
          wr_nxt    = 1'b1;
          addr_nxt  = pitch_addr;
          wdata_nxt = pitch_writedata;
          cnt_nxt   = '0;
        end
      end
      RD_REQ: begin
        cnt_nxt = cnt_inc;
        if (!avm_waitrequest) begin
          state_nxt = RD_WAIT;
          rd_nxt    = 1'b0;
        end else if (timeout) begin
          state_nxt = DONE;
          rd_nxt    = 1'b0;
          rdata_nxt = '0;
          fin_nxt   = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      RD_WAIT: begin
        cnt_nxt = cnt_inc;
        if (avm_readdatavalid) begin
          state_nxt = DONE;
          rdata_nxt = avm_readdata;
          fin_nxt   = 1'b1;
        end else if (timeout) begin
          state_nxt = DONE;
          rdata_nxt = '0;
          fin_nxt   = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      WR_REQ: begin
        cnt_nxt = cnt_inc;
        if (!avm_waitrequest) begin
          state_nxt = DONE;
          wr_nxt    = 1'b0;
          fin_nxt   = 1'b1;
        end else if (timeout) begin
          state_nxt = DONE;
          wr_nxt    = 1'b0;
          fin_nxt   = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                <= IDLE;
      cnt                  <= '0;
      avm_read             <= 1'b0;
      avm_write            <= 1'b0;
      avm_address          <= '0;
      avm_writedata        <= '0;
      pitch_readdata       <= '0;
      pitch_sdram_finished <= 1'b0;
      pitch_err            <= 1'b0;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      avm_read             <= rd_nxt;
      avm_write            <= wr_nxt;
      avm_address          <= addr_nxt;
      avm_writedata        <= wdata_nxt;
      pitch_readdata       <= rdata_nxt;
      pitch_sdram_finished <= fin_nxt;
      pitch_err            <= err_nxt;
    end
  end

endmodule

// File: doc/pitch_sdram_bridge.md
PITCH_SDRAM_BRIDGE -- requirements
Module: pitch_sdram_bridge

Interface
REQ-001 Parameter ADDR_W, default 23, client word-address width.
REQ-002 Parameter DATA_W, default 32, data width on both sides.
REQ-003 Parameter TIMEOUT_CYC, default 1023, max cycles per transaction before abort.
REQ-004 i_clk  input  1  single clock, rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 pitch_read  input  1  client read request, level, held until pitch_sdram_finished.
REQ-007 pitch_write  input  1  client write request, level, held until pitch_sdram_finished.
REQ-008 pitch_addr  input  ADDR_W  client word address.
REQ-009 pitch_writedata  input  DATA_W  client write data.
REQ-010 pitch_readdata  output  DATA_W  read result, registered.
REQ-011 pitch_sdram_finished  output  1  one-cycle completion pulse, registered.
REQ-012 pitch_err  output  1  one-cycle timeout flag, coincident with pitch_sdram_finished.
REQ-013 avm_address  output  ADDR_W  SDRAM master address.
REQ-014 avm_read / avm_write  output  1 each  Avalon-MM pipelined command strobes.
REQ-015 avm_writedata  output  DATA_W  write data; avm_byteenable output 4, constant 4'hF.
REQ-016 avm_readdata  input  DATA_W; avm_readdatavalid  input  1; avm_waitrequest  input  1.

Function
REQ-017 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE; exactly one transaction outstanding at a time.
REQ-018 IDLE: pitch_read=1 -> latch addr, go RD_REQ; else pitch_write=1 -> latch addr and writedata, go WR_REQ; both high -> read wins, write serviced next.
REQ-019 Client inputs SHALL be sampled only in IDLE; changes during a transaction are ignored.
REQ-020 RD_REQ: avm_read=1 with latched address; on cycle with avm_waitrequest=0 -> RD_WAIT, avm_read=0 next cycle.
REQ-021 RD_WAIT: avm_readdatavalid=1 -> capture avm_readdata into pitch_readdata, go DONE; readdatavalid outside RD_WAIT SHALL be ignored.
REQ-022 WR_REQ: avm_write=1 with latched address/data; on cycle with avm_waitrequest=0 -> DONE.
REQ-023 DONE: pitch_sdram_finished=1 for exactly one cycle, then IDLE unconditionally.
REQ-024 A request still asserted in the DONE cycle SHALL NOT be re-accepted; only the value seen in the following IDLE cycle counts.
REQ-025 Minimum latency, zero waitrequest, readdatavalid one cycle after accept: read = 4 cycles from request seen in IDLE to finished; write = 3 cycles.
REQ-026 Timeout counter SHALL clear on leaving IDLE and increment each cycle in RD_REQ/RD_WAIT/WR_REQ; at TIMEOUT_CYC -> deassert avm strobes, go DONE with pitch_err=1; aborted read SHALL set pitch_readdata to 0.
REQ-027 Timeout and completion on same cycle: completion wins, pitch_err=0.
REQ-028 pitch_readdata SHALL hold its value until the next completed or aborted read; writes do not alter it.
REQ-029 avm_read and avm_write SHALL never be high simultaneously; all outputs driven from registers.

Reset
REQ-030 i_rst_n low SHALL immediately force IDLE, counter 0, pitch_readdata 0, pitch_sdram_finished 0, pitch_err 0, avm_read 0, avm_write 0, avm_address 0, avm_writedata 0.
REQ-031 Reset mid-transaction SHALL abandon it with no finished pulse; late readdatavalid after reset is ignored.

Verification
REQ-032 Read, addr 23'h000400, waitrequest 0, readdatavalid+readdata 32'h6bd6e385 one cycle later -> avm_address 23'h000400, finished one cycle, pitch_readdata 32'h6bd6e385, 4-cycle latency.
REQ-033 Write, addr 1, data 32'h9a558c31, waitrequest high 3 cycles -> avm_write held 4 cycles with stable address/data, then one finished pulse, pitch_readdata unchanged.
REQ-034 pitch_read and pitch_write both high in IDLE -> read issued first, write issued after first finished, two finished pulses total.
REQ-035 readdatavalid never asserted, TIMEOUT_CYC=15 -> finished and pitch_err together 15 cycles after leaving IDLE, pitch_readdata 0.
REQ-036 i_rst_n low during RD_WAIT, readdatavalid 2 cycles after release -> no finished pulse, pitch_readdata stays 0, FSM IDLE.
REQ-037 Back-to-back 32 reads, client holding pitch_read across finished -> exactly 32 finished pulses, no duplicate avm_read.
